xcorr_peak_detect: RTL and testbench

//  Consumes the serial cross-correlation stream produced by the FFT/IFFT xcorr datapath.

---
 rtl/xcorr_pkg.sv | 21 ++
 rtl/xcorr_peak_detect_complex_mag_sq.sv | 92 +++++++++
 rtl/xcorr_peak_detect.sv | 141 ++++++++++++++
 tb/tb_xcorr_peak_detect.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xcorr_pkg.sv
// Shared constants and helpers for the FFT/IFFT cross-correlation datapath
// and its downstream peak detector.
package xcorr_pkg;

    localparam int unsigned DEF_INTEGER_SIZE = 16;
    localparam int unsigned DEF_FRACT_SIZE   = 16;
    localparam int unsigned DEF_NFFT         = 128;

    localparam int unsigned DATA_WIDTH = DEF_INTEGER_SIZE + DEF_FRACT_SIZE;
    localparam int unsigned LAG_W      = $clog2(DEF_NFFT);
    localparam int unsigned MAG_W      = 2 * DATA_WIDTH + 1;

    // Rescale a full-precision |x|^2 back to the sample Q format, clipping to all-ones.
    function automatic logic [DATA_WIDTH-1:0] sat_trunc(input logic [MAG_W-1:0] mag);
        if (|mag[MAG_W-1:DEF_FRACT_SIZE+DATA_WIDTH]) begin
            return '1;
        end
        return mag[DEF_FRACT_SIZE +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/xcorr_peak_detect_complex_mag_sq.sv
// Two-stage |x|^2 pipeline (square, then sum) carrying valid/index/last alongside the data.
module complex_mag_sq #(
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [IW-1:0]   flush_lim_i,
    input  logic            valid_i,
    input  logic            last_i,
    input  logic [IW-1:0]   index_i,
    input  logic [DW-1:0]   re_i,
    input  logic [DW-1:0]   im_i,
    output logic            valid_o,
    output logic            last_o,
    output logic [IW-1:0]   index_o,
    output logic [2*DW:0]   mag_o
);

    logic            s1_valid_q, s1_valid_d;
    logic            s1_last_q, s1_last_d;
    logic [IW-1:0]   s1_index_q, s1_index_d;
    logic [2*DW-1:0] rr_q, rr_d;
    logic [2*DW-1:0] ii_q, ii_d;

    logic            s2_valid_q, s2_valid_d;
    logic            s2_last_q, s2_last_d;
    logic [IW-1:0]   s2_index_q, s2_index_d;
    logic [2*DW:0]   mag_q, mag_d;

    logic signed [2*DW-1:0] rr_full;
    logic signed [2*DW-1:0] ii_full;

    always_comb begin
        rr_full = $signed(re_i) * $signed(re_i);
        ii_full = $signed(im_i) * $signed(im_i);

        s1_valid_d = valid_i;
        s1_last_d  = s1_last_q;
        s1_index_d = s1_index_q;
        rr_d       = rr_q;
        ii_d       = ii_q;
        if (valid_i) begin
            s1_last_d  = last_i;
            s1_index_d = index_i;
            rr_d       = rr_full;
            ii_d       = ii_full;
        end

        // Entries below the flush limit belong to the frame being abandoned.
        s2_valid_d = s1_valid_q & ~(flush_i & (s1_index_q < flush_lim_i));
        s2_last_d  = s2_last_q;
        s2_index_d = s2_index_q;
        mag_d      = mag_q;
        if (s1_valid_q) begin
            s2_last_d  = s1_last_q;
            s2_index_d = s1_index_q;
            mag_d      = {1'b0, rr_q} + {1'b0, ii_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_index_q <= '0;
            rr_q       <= '0;
            ii_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_index_q <= '0;
            mag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_index_q <= s1_index_d;
            rr_q       <= rr_d;
            ii_q       <= ii_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_index_q <= s2_index_d;
            mag_q      <= mag_d;
        end
    end

    assign valid_o = s2_valid_q;
    assign last_o  = s2_last_q;
    assign index_o = s2_index_q;
    assign mag_o   = mag_q;

endmodule

// File: rtl/xcorr_peak_detect.sv
// Peak search over one cross-correlation frame: bin counter, |x|^2 pipeline,
// running maximum and a held report of the peak bin, lag, magnitude and threshold hit.
module xcorr_peak_detect
    import xcorr_pkg::*;
#(
    parameter int unsigned INTEGER_SIZE = DEF_INTEGER_SIZE,
    parameter int unsigned FRACT_SIZE   = DEF_FRACT_SIZE,
    parameter int unsigned NFFT         = DEF_NFFT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_start,
    input  logic                                data_valid,
    input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in_r,
    input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in_i,
    input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  threshold,
    output logic                                peak_done,
    output logic                                peak_found,
    output logic [$clog2(NFFT)-1:0]             peak_lag,
    output logic [$clog2(NFFT)-1:0]             peak_index,
    output logic [INTEGER_SIZE+FRACT_SIZE-1:0]  peak_mag
);

    localparam int unsigned DW = INTEGER_SIZE + FRACT_SIZE;
    localparam int unsigned LW = $clog2(NFFT);
    localparam int unsigned MW = 2 * DW + 1;
    localparam logic [LW-1:0] LAST_IDX = LW'(NFFT - 1);

    function automatic logic [DW-1:0] sat_mag(input logic [MW-1:0] m);
        if (|m[MW-1:FRACT_SIZE+DW]) begin
            return '1;
        end
        return m[FRACT_SIZE +: DW];
    endfunction

    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] in_index;
    logic          in_last;

    logic          mag_valid;
    logic          mag_last;
    logic [LW-1:0] mag_index;
    logic [MW-1:0] mag;
    logic          s3_go;

    logic [MW-1:0] max_q, max_d;
    logic [LW-1:0] best_q, best_d;

    logic          done_q, done_d;
    logic          found_q, found_d;
    logic [LW-1:0] lag_q, lag_d;
    logic [LW-1:0] index_q, index_d;
    logic [DW-1:0] pmag_q, pmag_d;
    logic [DW-1:0] sat_val;

    always_comb begin
        in_index = frame_start ? '0 : cnt_q;
        in_last  = (in_index == LAST_IDX);
        cnt_d    = cnt_q;
        if (frame_start) begin
            cnt_d = '0;
        end
        if (data_valid) begin
            cnt_d = in_index + LW'(1);
        end
    end

    complex_mag_sq #(
        .DW (DW),
        .IW (LW)
    ) u_mag (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (frame_start),
        .flush_lim_i (cnt_q),
        .valid_i     (data_valid),
        .last_i      (in_last),
        .index_i     (in_index),
        .re_i        (in_r),
        .im_i        (in_i),
        .valid_o     (mag_valid),
        .last_o      (mag_last),
        .index_o     (mag_index),
        .mag_o       (mag)
    );

    always_comb begin
        // A finished frame's tail has indices at or above the count, so it survives a restart.
        s3_go = mag_valid & ~(frame_start & (mag_index < cnt_q));

        max_d  = max_q;
        best_d = best_q;
        if (s3_go && ((mag_index == '0) || (mag > max_q))) begin
            max_d  = mag;
            best_d = mag_index;
        end

        sat_val = sat_mag(max_d);
        done_d  = s3_go & mag_last;
        found_d = found_q;
        lag_d   = lag_q;
        index_d = index_q;
        pmag_d  = pmag_q;
        if (done_d) begin
            found_d = (sat_val > threshold);
            // index - NFFT wraps onto the same LW-bit pattern as index itself.
            lag_d   = best_d;
            index_d = best_d;
            pmag_d  = sat_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            max_q   <= '0;
            best_q  <= '0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            lag_q   <= '0;
            index_q <= '0;
            pmag_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            best_q  <= best_d;
            done_q  <= done_d;
            found_q <= found_d;
            lag_q   <= lag_d;
            index_q <= index_d;
            pmag_q  <= pmag_d;
        end
    end

    assign peak_done  = done_q;
    assign peak_found = found_q;
    assign peak_lag   = lag_q;
    assign peak_index = index_q;
    assign peak_mag   = pmag_q;

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// Scoreboard bench for xcorr_peak_detect: expected peaks queued as frames are driven,
// popped and compared whenever peak_done pulses.
module tb_xcorr_peak_detect;

    localparam int NFFT = 128;
    localparam int DW   = 32;
    localparam int LW   = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          data_valid;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_i;
    logic [DW-1:0] threshold;
    logic          peak_done;
    logic          peak_found;
    logic [LW-1:0] peak_lag;
    logic [LW-1:0] peak_index;
    logic [DW-1:0] peak_mag;

    xcorr_peak_detect #(
        .INTEGER_SIZE (16),
        .FRACT_SIZE   (16),
        .NFFT         (NFFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .data_valid  (data_valid),
        .in_r        (in_r),
        .in_i        (in_i),
        .threshold   (threshold),
        .peak_done   (peak_done),
        .peak_found  (peak_found),
        .peak_lag    (peak_lag),
        .peak_index  (peak_index),
        .peak_mag    (peak_mag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] idx;
        logic [LW-1:0] lag;
        logic [DW-1:0] mag;
        logic          found;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            n_done = 0;
    logic [DW-1:0] fr_r[NFFT];
    logic [DW-1:0] fr_i[NFFT];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && peak_done) begin
            n_done++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: peak_done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = sb.pop_front();
                n_checks += 5;
                if (peak_index !== mon_e.idx) begin
                    n_fail++;
                    $display("FAIL sb_index: got %0d, required %0d", peak_index, mon_e.idx);
                end
                if (peak_lag !== mon_e.lag) begin
                    n_fail++;
                    $display("FAIL sb_lag: got %0d, required %0d", $signed(peak_lag),
                             $signed(mon_e.lag));
                end
                if (peak_mag !== mon_e.mag) begin
                    n_fail++;
                    $display("FAIL sb_mag: got %h, required %h", peak_mag, mon_e.mag);
                end
                if (peak_found !== mon_e.found) begin
                    n_fail++;
                    $display("FAIL sb_found: got %b, required %b", peak_found, mon_e.found);
                end
                if (cyc != mon_e.due) begin
                    n_fail++;
                    $display("FAIL sb_latency: done at cycle %0d, required %0d", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic drive_idle();
        @(negedge clk);
        frame_start = 1'b0;
        data_valid  = 1'b0;
        in_r        = '0;
        in_i        = '0;
    endtask

    task automatic drive_sample(input logic fs, input logic [DW-1:0] r, input logic [DW-1:0] i);
        @(negedge clk);
        frame_start = fs;
        data_valid  = 1'b1;
        in_r        = r;
        in_i        = i;
    endtask

    task automatic clear_frame();
        for (int b = 0; b < NFFT; b++) begin
            fr_r[b] = '0;
            fr_i[b] = '0;
        end
    endtask

    // Model: |x|^2 at full precision, earliest strict maximum, Q rescale with saturation.
    task automatic run_frame(input logic fs, input int gap_pct, input logic [DW-1:0] thr);
        logic signed [63:0] rr;
        logic signed [63:0] ii;
        logic [64:0]        m;
        logic [64:0]        best;
        int                 bi;
        exp_t               e;
        threshold = thr;
        best = '0;
        bi   = 0;
        for (int b = 0; b < NFFT; b++) begin
            rr = $signed(fr_r[b]) * $signed(fr_r[b]);
            ii = $signed(fr_i[b]) * $signed(fr_i[b]);
            m  = {1'b0, rr} + {1'b0, ii};
            if (b == 0 || m > best) begin
                best = m;
                bi   = b;
            end
        end
        e.idx   = LW'(bi);
        e.lag   = LW'(bi < NFFT / 2 ? bi : bi - NFFT);
        e.mag   = (|best[64:48]) ? '1 : best[47:16];
        e.found = (e.mag > thr);
        for (int b = 0; b < NFFT; b++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(99) < gap_pct) drive_idle();
            end
            drive_sample(fs && (b == 0), fr_r[b], fr_i[b]);
            if (b == NFFT - 1) begin
                e.due = cyc + 3;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        drive_idle();
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        data_valid  = 1'b0;
        in_r = '0;
        in_i = '0;
        threshold = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({peak_done, peak_found, peak_lag, peak_index, peak_mag} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: done=%b found=%b lag=%h idx=%h mag=%h, required all 0",
                     peak_done, peak_found, peak_lag, peak_index, peak_mag);
        end
        rst = 1'b0;
        drive_idle();
    endtask

    task automatic test_impulse_real();
        clear_frame();
        fr_r[5] = 32'h0001_0000;
        run_frame(1'b1, 0, 32'h0000_8000);
        drive_idle();
        wait_drain();
        n_checks += 3;
        if (peak_index !== 7'd5) begin
            n_fail++;
            $display("FAIL real_index: got %0d, required 5", peak_index);
        end
        if (peak_lag !== 7'd5) begin
            n_fail++;
            $display("FAIL real_lag: got %0d, required 5", $signed(peak_lag));
        end
        if (peak_mag !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL real_mag: got %h, required 00010000", peak_mag);
        end
    endtask

    task automatic test_impulse_imag();
        logic [LW-1:0] lag_m8;
        lag_m8 = 7'b111_1000;
        clear_frame();
        fr_i[120] = 32'h0002_0000;
        run_frame(1'b1, 0, 32'h0003_0000);
        drive_idle();
        wait_drain();
        n_checks += 3;
        if (peak_lag !== lag_m8) begin
            n_fail++;
            $display("FAIL imag_lag: got %0d, required -8", $signed(peak_lag));
        end
        if (peak_mag !== 32'h0004_0000) begin
            n_fail++;
            $display("FAIL imag_mag: got %h, required 00040000", peak_mag);
        end
        if (peak_found !== 1'b1) begin
            n_fail++;
            $display("FAIL imag_found: got %b, required 1", peak_found);
        end
    endtask

    task automatic test_tie_and_zero();
        clear_frame();
        fr_r[3] = 32'h0001_0000;
        fr_i[9] = 32'h0001_0000;
        run_frame(1'b1, 0, 32'h0001_0000);
        drive_idle();
        wait_drain();
        n_checks += 2;
        if (peak_index !== 7'd3) begin
            n_fail++;
            $display("FAIL tie_index: got %0d, required 3", peak_index);
        end
        if (peak_found !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_found_equal_thr: got %b, required 0", peak_found);
        end
        clear_frame();
        run_frame(1'b1, 0, 32'h0000_0000);
        drive_idle();
        wait_drain();
        n_checks += 2;
        if (peak_index !== 7'd0 || peak_mag !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_frame: idx=%0d mag=%h, required 0 and 0", peak_index, peak_mag);
        end
        if (peak_found !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_found: got %b, required 0", peak_found);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = n_done;
        clear_frame();
        fr_r[10] = 32'h0002_0000;
        run_frame(1'b1, 0, 32'h0);
        clear_frame();
        fr_i[100] = 32'hFFFF_0000;
        run_frame(1'b1, 0, 32'h0);
        clear_frame();
        fr_r[63] = 32'h0000_8000;
        run_frame(1'b0, 0, 32'h0);
        drive_idle();
        wait_drain();
        n_checks += 2;
        if (n_done - d0 != 3) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d, required 3", n_done - d0);
        end
        if (peak_index !== 7'd63 || peak_mag !== 32'h0000_4000) begin
            n_fail++;
            $display("FAIL b2b_last: idx=%0d mag=%h, required 63 and 00004000", peak_index,
                     peak_mag);
        end
    endtask

    task automatic test_saturation();
        clear_frame();
        fr_r[7] = 32'h8000_0000;
        fr_i[7] = 32'h8000_0000;
        run_frame(1'b1, 0, 32'hFFFF_FFFE);
        drive_idle();
        wait_drain();
        n_checks += 2;
        if (peak_mag !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_mag: got %h, required ffffffff", peak_mag);
        end
        if (peak_index !== 7'd7) begin
            n_fail++;
            $display("FAIL sat_index: got %0d, required 7", peak_index);
        end
    endtask

    task automatic test_gaps();
        int d0 = n_done;
        clear_frame();
        fr_r[64] = 32'h0003_0000;
        run_frame(1'b1, 50, 32'h0009_0000);
        drive_idle();
        wait_drain();
        n_checks += 2;
        if (n_done - d0 != 1) begin
            n_fail++;
            $display("FAIL gaps_done_count: got %0d, required 1", n_done - d0);
        end
        if (peak_lag !== 7'h40 || peak_mag !== 32'h0009_0000) begin
            n_fail++;
            $display("FAIL gaps_result: lag=%0d mag=%h, required -64 and 00090000",
                     $signed(peak_lag), peak_mag);
        end
    endtask

    task automatic test_frame_start_abort();
        int d0 = n_done;
        for (int b = 0; b <= 40; b++) begin
            drive_sample(b == 0, (b == 20) ? 32'h0010_0000 : 32'h0, 32'h0);
        end
        clear_frame();
        fr_r[77] = 32'h0002_0000;
        run_frame(1'b1, 0, 32'h0);
        drive_idle();
        wait_drain();
        n_checks += 2;
        if (n_done - d0 != 1) begin
            n_fail++;
            $display("FAIL abort_done_count: got %0d, required 1", n_done - d0);
        end
        if (peak_index !== 7'd77 || peak_mag !== 32'h0004_0000) begin
            n_fail++;
            $display("FAIL abort_result: idx=%0d mag=%h, required 77 and 00040000", peak_index,
                     peak_mag);
        end
    endtask

    task automatic test_pending_done();
        int d0 = n_done;
        clear_frame();
        fr_i[30] = 32'h0001_0000;
        run_frame(1'b1, 0, 32'h0);
        drive_idle();
        drive_idle();
        clear_frame();
        fr_r[90] = 32'h0000_4000;
        run_frame(1'b1, 0, 32'h0);
        drive_idle();
        wait_drain();
        n_checks += 2;
        if (n_done - d0 != 2) begin
            n_fail++;
            $display("FAIL pending_done_count: got %0d, required 2", n_done - d0);
        end
        if (peak_index !== 7'd90 || peak_mag !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL pending_result: idx=%0d mag=%h, required 90 and 00001000", peak_index,
                     peak_mag);
        end
    endtask

    task automatic test_rst_midframe();
        int d0;
        for (int b = 0; b <= 40; b++) begin
            drive_sample(b == 0, (b == 10) ? 32'h0004_0000 : 32'h0, 32'h0);
        end
        @(negedge clk);
        data_valid  = 1'b0;
        frame_start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({peak_done, peak_found, peak_lag, peak_index, peak_mag} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: found=%b lag=%h idx=%h mag=%h, required all 0",
                     peak_found, peak_lag, peak_index, peak_mag);
        end
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        clear_frame();
        fr_r[2] = 32'h0001_0000;
        run_frame(1'b0, 0, 32'h0);
        drive_idle();
        wait_drain();
        n_checks++;
        if (n_done - d0 != 1 || peak_index !== 7'd2) begin
            n_fail++;
            $display("FAIL rst_recover: dones=%0d idx=%0d, required 1 and 2", n_done - d0,
                     peak_index);
        end
    endtask

    initial begin
        test_reset();
        test_impulse_real();
        test_impulse_imag();
        test_tie_and_zero();
        test_back_to_back();
        test_saturation();
        test_gaps();
        test_frame_start_abort();
        test_pending_done();
        test_rst_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
